// File: rtl/cdc_src_fsm_buf_if.sv
// Interface bundling the source push channel and the asynchronous
// req/ack/data channel of cdc_src_fsm_buf.
// slave  : the sender block itself.
// master : whoever drives it (source logic plus the destination receiver).
interface cdc_src_fsm_buf_if #(
  parameter type T     = logic [31:0],
  parameter int  DEPTH = 2
);

  localparam int FillW = $clog2(DEPTH + 1);

  T                 data_i;
  logic             valid_i;
  logic             ready_o;
  logic             async_req_o;
  logic             async_ack_i;
  T                 async_data_o;
  logic [FillW-1:0] fill_o;
  logic             busy_o;

  modport slave (
    input  data_i,
    input  valid_i,
    input  async_ack_i,
    output ready_o,
    output async_req_o,
    output async_data_o,
    output fill_o,
    output busy_o
  );

  modport master (
    output data_i,
    output valid_i,
    output async_ack_i,
    input  ready_o,
    input  async_req_o,
    input  async_data_o,
    input  fill_o,
    input  busy_o
  );

endinterface

// File: rtl/cdc_src_fsm_buf.sv
// Source-side sender for the asynchronous req/ack/data handshake.
// Source words are buffered in a DEPTH-entry FIFO and drained one per
// ack round trip, using either 2-phase (toggle) or 4-phase (return to
// zero) signalling. async_req_o and async_data_o come straight from flops
// so the destination domain never sees combinational glitches, and the
// data word is held stable from one launch until the next.
// Optional feature macro: CDC_SRC_TIMEOUT_EN adds a sticky timeout_o flag
// that rises when a handshake has been pending for TIMEOUT_CYC cycles.
module cdc_src_fsm_buf #(
  parameter type T           = logic [31:0],
  parameter int  DEPTH       = 2,
  parameter int  SYNC_STAGES = 2,
  parameter bit  FOUR_PHASE  = 1'b0
`ifdef CDC_SRC_TIMEOUT_EN
  ,
  parameter int  TIMEOUT_CYC = 1024
`endif
) (
  input  logic clk_i,
  input  logic rst_ni,
`ifdef CDC_SRC_TIMEOUT_EN
  output logic timeout_o,
`endif
  cdc_src_fsm_buf_if.slave bus
);

  localparam int PtrW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int FillW = $clog2(DEPTH + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    REL  = 2'd2
  } state_e;

  state_e                 state_q, state_d;
  T                       mem_q [DEPTH];
  logic [PtrW-1:0]        wrPtr_q, wrPtr_d;
  logic [PtrW-1:0]        rdPtr_q, rdPtr_d;
  logic [FillW-1:0]       fill_q, fill_d;
  logic [SYNC_STAGES-1:0] ackSync_q;
  logic                   req_q, req_d;
  T                       data_q, data_d;

  logic ackS;
  logic empty;
  logic full;
  logic push;
  logic launch;
  logic reqDrop;

  // Pointers advance modulo DEPTH, so non-power-of-two depths wrap cleanly.
  function automatic logic [PtrW-1:0] ptrInc(input logic [PtrW-1:0] ptr);
    if (ptr == PtrW'(DEPTH - 1)) begin
      return '0;
    end
    return ptr + PtrW'(1);
  endfunction

  assign empty = (fill_q == '0);
  assign full  = (fill_q == FillW'(DEPTH));
  assign push  = bus.valid_i && !full;
  assign ackS  = ackSync_q[SYNC_STAGES-1];

  // Ack synchroniser: the only place async_ack_i is sampled.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ackSync_q <= '0;
    end else begin
      ackSync_q <= {ackSync_q[SYNC_STAGES-2:0], bus.async_ack_i};
    end
  end

  // Handshake FSM: decides when to launch the FIFO head and when to release req.
  always_comb begin
    state_d = state_q;
    launch  = 1'b0;
    reqDrop = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (!empty) begin
          launch  = 1'b1;
          state_d = REQ;
        end
      end
      REQ: begin
        if (FOUR_PHASE) begin
          if (ackS) begin
            reqDrop = 1'b1;
            state_d = REL;
          end
        end else if (ackS == req_q) begin
          if (!empty) begin
            launch = 1'b1;
          end else begin
            state_d = IDLE;
          end
        end
      end
      REL: begin
        if (!ackS) begin
          if (!empty) begin
            launch  = 1'b1;
            state_d = REQ;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Next values for the flopped req/data outputs and the FIFO bookkeeping.
  always_comb begin
    req_d   = req_q;
    data_d  = data_q;
    wrPtr_d = wrPtr_q;
    rdPtr_d = rdPtr_q;
    fill_d  = fill_q;
    if (launch) begin
      data_d  = mem_q[rdPtr_q];
      req_d   = FOUR_PHASE ? 1'b1 : ~req_q;
      rdPtr_d = ptrInc(rdPtr_q);
    end else if (reqDrop) begin
      req_d = 1'b0;
    end
    if (push) begin
      wrPtr_d = ptrInc(wrPtr_q);
    end
    unique case ({push, launch})
      2'b10:   fill_d = fill_q + FillW'(1);
      2'b01:   fill_d = fill_q - FillW'(1);
      default: fill_d = fill_q;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FIFO control and output registers; reset discards any buffered words.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wrPtr_q <= '0;
      rdPtr_q <= '0;
      fill_q  <= '0;
      req_q   <= 1'b0;
      data_q  <= '0;
    end else begin
      wrPtr_q <= wrPtr_d;
      rdPtr_q <= rdPtr_d;
      fill_q  <= fill_d;
      req_q   <= req_d;
      data_q  <= data_d;
    end
  end

  // FIFO storage; contents are only meaningful below the fill level.
  always_ff @(posedge clk_i) begin
    if (push) begin
      mem_q[wrPtr_q] <= bus.data_i;
    end
  end

  assign bus.ready_o      = !full;
  assign bus.async_req_o  = req_q;
  assign bus.async_data_o = data_q;
  assign bus.fill_o       = fill_q;
  assign bus.busy_o       = (state_q != IDLE);

`ifdef CDC_SRC_TIMEOUT_EN
  logic [15:0] toCnt_q, toCnt_d;
  logic        timeout_q, timeout_d;

  // Wait counter: restarts on every launch or state change, saturates at
  // the top; the flag sets on the edge the count reaches TIMEOUT_CYC.
  always_comb begin
    toCnt_d   = toCnt_q;
    timeout_d = timeout_q;
    if (launch || (state_d != state_q)) begin
      toCnt_d = '0;
    end else if (((state_q == REQ) || (state_q == REL)) && (toCnt_q != 16'hFFFF)) begin
      toCnt_d = toCnt_q + 16'd1;
    end
    if (toCnt_d == 16'(TIMEOUT_CYC)) begin
      timeout_d = 1'b1;
    end
  end

  // Timeout registers; the flag is sticky until reset.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      toCnt_q   <= '0;
      timeout_q <= 1'b0;
    end else begin
      toCnt_q   <= toCnt_d;
      timeout_q <= timeout_d;
    end
  end

  assign timeout_o = timeout_q;
`endif

endmodule

// File: tb/tb_cdc_src_fsm_buf.sv
// Directed testbench for cdc_src_fsm_buf.
// Instance A: 2-phase, DEPTH=2, receiver model acks 6 cycles after seeing req.
// Instance B: 4-phase, DEPTH=2, ack is req delayed by 3 cycles (driven inline).
// Instance C: 2-phase, DEPTH=3, receiver model with random ack delays.
// Instance D (CDC_SRC_TIMEOUT_EN only): 2-phase with TIMEOUT_CYC=8.
module tb_cdc_src_fsm_buf;

  localparam int ACK_DLY_A = 6;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  int compared   = 0;
  int mismatched = 0;

  cdc_src_fsm_buf_if #(.T(logic [31:0]), .DEPTH(2)) busA ();
  cdc_src_fsm_buf_if #(.T(logic [31:0]), .DEPTH(2)) busB ();
  cdc_src_fsm_buf_if #(.T(logic [31:0]), .DEPTH(3)) busC ();

  logic ackA = 1'b0;
  logic injA = 1'b0;
  logic ackB = 1'b0;
  logic ackC = 1'b0;

  assign busA.async_ack_i = ackA ^ injA;
  assign busB.async_ack_i = ackB;
  assign busC.async_ack_i = ackC;

`ifdef CDC_SRC_TIMEOUT_EN
  cdc_src_fsm_buf_if #(.T(logic [31:0]), .DEPTH(2)) busD ();
  logic ackD = 1'b0;
  logic toA, toB, toC, toD;
  assign busD.async_ack_i = ackD;
`endif

  cdc_src_fsm_buf #(.T(logic [31:0]), .DEPTH(2), .SYNC_STAGES(2), .FOUR_PHASE(1'b0)) u2p (
    .clk_i (clk),
    .rst_ni(rst_n),
`ifdef CDC_SRC_TIMEOUT_EN
    .timeout_o(toA),
`endif
    .bus   (busA)
  );

  cdc_src_fsm_buf #(.T(logic [31:0]), .DEPTH(2), .SYNC_STAGES(2), .FOUR_PHASE(1'b1)) u4p (
    .clk_i (clk),
    .rst_ni(rst_n),
`ifdef CDC_SRC_TIMEOUT_EN
    .timeout_o(toB),
`endif
    .bus   (busB)
  );

  cdc_src_fsm_buf #(.T(logic [31:0]), .DEPTH(3), .SYNC_STAGES(2), .FOUR_PHASE(1'b0)) u3 (
    .clk_i (clk),
    .rst_ni(rst_n),
`ifdef CDC_SRC_TIMEOUT_EN
    .timeout_o(toC),
`endif
    .bus   (busC)
  );

`ifdef CDC_SRC_TIMEOUT_EN
  cdc_src_fsm_buf #(.T(logic [31:0]), .DEPTH(2), .SYNC_STAGES(2), .FOUR_PHASE(1'b0),
                    .TIMEOUT_CYC(8)) uto (
    .clk_i    (clk),
    .rst_ni   (rst_n),
    .timeout_o(toD),
    .bus      (busD)
  );
`endif

  // Every comparison in the bench goes through here.
  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    compared++;
    if (got !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Receiver model for A: records each new word, acks ACK_DLY_A cycles later,
  // and keeps running counts of req toggles and full-FIFO observations.
  int          cntA      = 0;
  logic        prevReqA  = 1'b0;
  int          togglesA  = 0;
  int          sawFullA  = 0;
  int          readyBadA = 0;
  logic [31:0] recvA[$];

  always @(negedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ackA     <= 1'b0;
      cntA     <= 0;
      prevReqA <= 1'b0;
    end else begin
      if (busA.async_req_o != prevReqA) togglesA <= togglesA + 1;
      prevReqA <= busA.async_req_o;
      if (busA.fill_o == 2'd2) begin
        sawFullA <= sawFullA + 1;
        if (busA.ready_o) readyBadA <= readyBadA + 1;
      end
      if (busA.async_req_o != ackA) begin
        if (cntA == 0) recvA.push_back(busA.async_data_o);
        if (cntA == ACK_DLY_A) begin
          ackA <= busA.async_req_o;
          cntA <= 0;
        end else begin
          cntA <= cntA + 1;
        end
      end
    end
  end

  // Receiver model for C: random ack delay of 1..20 cycles per word.
  int          cntC = 0;
  int          dlyC = 1;
  logic [31:0] recvC[$];

  always @(negedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ackC <= 1'b0;
      cntC <= 0;
    end else if (busC.async_req_o != ackC) begin
      if (cntC == 0) begin
        recvC.push_back(busC.async_data_o);
        dlyC <= int'($urandom_range(20, 1));
      end
      if ((cntC != 0) && (cntC >= dlyC)) begin
        ackC <= busC.async_req_o;
        cntC <= 0;
      end else begin
        cntC <= cntC + 1;
      end
    end
  end

  // Present one word to A and hold it until it is accepted on an edge.
  task automatic applyStimulus(input logic [31:0] word);
    int guard;
    guard = 0;
    busA.data_i  = word;
    busA.valid_i = 1'b1;
    while (!busA.ready_o && guard < 200) begin
      step();
      guard++;
    end
    checkOutput("a.pushTimeout", guard >= 200, 0);
    step();
  endtask

  task automatic waitIdleA(input int bound);
    int n;
    n = 0;
    while ((busA.busy_o || busA.fill_o != 0) && n < bound) begin
      step();
      n++;
    end
    checkOutput("a.idleTimeout", n >= bound, 0);
  endtask

  // Ack for B is req delayed by three cycles.
  logic [2:0] dlyB = 3'b000;
  task automatic stepB();
    step();
    dlyB = {dlyB[1:0], busB.async_req_o};
    ackB = dlyB[2];
  endtask

  int          base;
  int          t0;
  int          f0;
  int          b0;
  int          bad;
  int          idx;
  int          launched;
  int          cycles;
  int          fillErr;
  logic        sawFullC;
  logic        prevReqC;
  logic        readyPre;
  logic        validPre;
  logic [10:0] expReqB;
  logic [10:0] expBusyB;

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  // Main directed sequence.
  initial begin
    busA.valid_i = 1'b0; busA.data_i = '0;
    busB.valid_i = 1'b0; busB.data_i = '0;
    busC.valid_i = 1'b0; busC.data_i = '0;
`ifdef CDC_SRC_TIMEOUT_EN
    busD.valid_i = 1'b0; busD.data_i = '0;
`endif
    repeat (3) @(posedge clk);
    #1;

    checkOutput("rst.reqA",   busA.async_req_o,  0);
    checkOutput("rst.fillA",  busA.fill_o,       0);
    checkOutput("rst.readyA", busA.ready_o,      1);
    checkOutput("rst.busyA",  busA.busy_o,       0);
    checkOutput("rst.dataA",  busA.async_data_o, 0);
    checkOutput("rst.reqB",   busB.async_req_o,  0);
    checkOutput("rst.readyC", busC.ready_o,      1);

    @(negedge clk);
    rst_n = 1'b1;
    step();

    // 2-phase burst of five words into a two-entry FIFO.
    base = recvA.size(); t0 = togglesA; f0 = sawFullA; b0 = readyBadA;
    for (int i = 0; i < 5; i++) applyStimulus(32'hA5A5_0001 + 32'(i));
    busA.valid_i = 1'b0;
    waitIdleA(400);
    checkOutput("a.toggles",   togglesA - t0, 5);
    checkOutput("a.reqEnd",    busA.async_req_o, 1);
    checkOutput("a.recvCount", recvA.size() - base, 5);
    for (int i = 0; i < 5; i++) begin
      if (base + i < recvA.size()) checkOutput("a.order", recvA[base + i], 32'hA5A5_0001 + 32'(i));
    end
    checkOutput("a.sawFull",  sawFullA - f0 > 0, 1);
    checkOutput("a.readyLow", readyBadA - b0, 0);

    // Stray ack activity while idle must be ignored.
    bad  = 0;
    base = recvA.size();
    injA = 1'b1;
    for (int i = 0; i < 12; i++) begin
      if (i == 6) injA = 1'b0;
      step();
      if (busA.busy_o || busA.fill_o != 0 || busA.async_req_o != 1'b1) bad++;
    end
    checkOutput("inj.noAction", bad, 0);
    applyStimulus(32'hC0DE_0001);
    busA.valid_i = 1'b0;
    checkOutput("inj.reqBefore", busA.async_req_o, 1);
    checkOutput("inj.fillPush",  busA.fill_o, 1);
    step();
    checkOutput("inj.reqLaunch", busA.async_req_o, 0);
    checkOutput("inj.busy",      busA.busy_o, 1);
    checkOutput("inj.data",      busA.async_data_o, 32'hC0DE_0001);
    checkOutput("inj.fillPop",   busA.fill_o, 0);
    waitIdleA(200);
    checkOutput("inj.recvCount", recvA.size() - base, 1);
    if (recvA.size() > base) checkOutput("inj.recvWord", recvA[base], 32'hC0DE_0001);

    // Reset in the middle of a transfer with two words buffered.
    applyStimulus(32'hBEEF_0001);
    applyStimulus(32'hBEEF_0002);
    applyStimulus(32'hBEEF_0003);
    busA.valid_i = 1'b0;
    checkOutput("mid.preFill", busA.fill_o, 2);
    checkOutput("mid.preReq",  busA.async_req_o, 1);
    checkOutput("mid.preBusy", busA.busy_o, 1);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("mid.req",   busA.async_req_o, 0);
    checkOutput("mid.fill",  busA.fill_o, 0);
    checkOutput("mid.ready", busA.ready_o, 1);
    checkOutput("mid.busy",  busA.busy_o, 0);
    @(negedge clk);
    rst_n = 1'b1;
    bad = 0;
    for (int i = 0; i < 5; i++) begin
      step();
      if (busA.async_req_o || busA.busy_o || busA.fill_o != 0 || busA.async_data_o != 0) bad++;
    end
    checkOutput("mid.noLaunch", bad, 0);

    // 4-phase single word, cycle-by-cycle trace.
    expReqB  = 11'b000_0001_1111;
    expBusyB = 11'b011_1111_1111;
    busB.data_i  = 32'h1234_5678;
    busB.valid_i = 1'b1;
    stepB();
    busB.valid_i = 1'b0;
    checkOutput("b.fillPush", busB.fill_o, 1);
    checkOutput("b.reqPush",  busB.async_req_o, 0);
    checkOutput("b.busyPush", busB.busy_o, 0);
    for (int c = 1; c <= 11; c++) begin
      stepB();
      checkOutput($sformatf("b.req.c%0d", c),  busB.async_req_o, expReqB[c-1]);
      checkOutput($sformatf("b.busy.c%0d", c), busB.busy_o,      expBusyB[c-1]);
      if (c == 1) begin
        checkOutput("b.data",    busB.async_data_o, 32'h1234_5678);
        checkOutput("b.fillPop", busB.fill_o, 0);
      end
    end

    // DEPTH=3, ten words with random valid and random ack delays.
    base = recvC.size(); idx = 0; launched = 0; cycles = 0; fillErr = 0;
    sawFullC = 1'b0; prevReqC = busC.async_req_o;
    while ((idx < 10 || busC.busy_o || busC.fill_o != 0) && cycles < 3000) begin
      if (idx < 10) begin
        busC.valid_i = 1'($urandom_range(1, 0));
        busC.data_i  = 32'h3C3C_0000 + 32'(idx);
      end else begin
        busC.valid_i = 1'b0;
      end
      readyPre = busC.ready_o;
      validPre = busC.valid_i;
      step();
      cycles++;
      if (validPre && readyPre) idx++;
      if (busC.async_req_o != prevReqC) begin
        launched++;
        prevReqC = busC.async_req_o;
      end
      if (int'(busC.fill_o) != idx - launched) fillErr++;
      if (busC.fill_o == 2'd3) sawFullC = 1'b1;
    end
    busC.valid_i = 1'b0;
    checkOutput("c.timeout",   cycles >= 3000, 0);
    checkOutput("c.recvCount", recvC.size() - base, 10);
    for (int i = 0; i < 10; i++) begin
      if (base + i < recvC.size()) checkOutput("c.order", recvC[base + i], 32'h3C3C_0000 + 32'(i));
    end
    checkOutput("c.launches",  launched, 10);
    checkOutput("c.fillTrack", fillErr, 0);
    checkOutput("c.sawFull",   sawFullC, 1);

`ifdef CDC_SRC_TIMEOUT_EN
    // Timeout: ack withheld after launch, flag rises on the 8th edge in REQ.
    busD.data_i  = 32'hD00D_0001;
    busD.valid_i = 1'b1;
    step();
    busD.valid_i = 1'b0;
    step();
    checkOutput("to.req",    busD.async_req_o, 1);
    checkOutput("to.start",  toD, 0);
    repeat (7) step();
    checkOutput("to.before", toD, 0);
    step();
    checkOutput("to.set",    toD, 1);
    ackD = 1'b1;
    repeat (6) step();
    checkOutput("to.idle",   busD.busy_o, 0);
    checkOutput("to.sticky", toD, 1);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
